piso_tx: RTL
============

Name: piso_tx

Overview:
- Parallel-in, serial-out framed transmitter. It sits on the driving side of a serial link whose receive end is a chain of clocked D flip-flops sampling one bit per bit period.
- Accepts a WIDTH-bit word through a valid/ready handshake and emits it on a single line:
  - start bit (0),
  - data bits LSB first,
  - optional parity bit,
  - stop bit (1).
- The line idles high. The bit period is set by a clock divider.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- CLK_DIV, 4, clock cycles per serial bit (>=1). The divider counter is max(1, clog2(CLK_DIV)) bits wide.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd. Any other value is treated as 0.

Ports:
- clk, input, 1, system clock; all state changes on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- din, input, WIDTH, parallel word to transmit; sampled only on acceptance.
- din_valid, input, 1, din holds a word to send.
- din_ready, output, 1, block can accept a word this cycle.
- tx, output, 1, serial line (registered); idle high.
- busy, output, 1, a frame is in progress.
- done, output, 1, one-cycle pulse at the end of each frame.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
  - While rst_n=0: tx=1, din_ready=1, busy=0, done=0, state=IDLE, all counters and the shift register cleared.
  - Assertion mid-frame aborts the frame immediately; tx returns high without waiting for a clock edge.
- States: IDLE, START, DATA, PAR, STOP.
  - PAR is skipped when PARITY=0.
- Bit timing: divider counter div_cnt counts 0..CLK_DIV-1 in every non-IDLE state. A bit ends when div_cnt==CLK_DIV-1; div_cnt then wraps to 0.
- Handshake:
  - din_ready=1 only in IDLE.
  - Acceptance happens on a rising edge with din_valid=1 and din_ready=1. At that edge: din is latched into the shift register, parity is computed from din, state becomes START, div_cnt=0, bit index=0.
  - din and din_valid are ignored while not in IDLE. Dropping din_valid mid-frame has no effect.
- Frame timing, with acceptance at edge k and P = 1 if PARITY != 0, else 0:
  - tx=0 (start bit) from edge k through edge k+CLK_DIV.
  - Data bit i (i = 0..WIDTH-1) is driven from edge k+(1+i)*CLK_DIV. The shift register shifts right at each data-bit end.
  - Parity bit, if enabled, from edge k+(1+WIDTH)*CLK_DIV:
    - even mode: XOR of the word;
    - odd mode: inverted XOR.
  - Stop bit tx=1 from edge k+(1+WIDTH+P)*CLK_DIV.
  - At edge k+(2+WIDTH+P)*CLK_DIV: state becomes IDLE, done=1 for exactly one cycle, din_ready=1.
- busy=1 from edge k until the edge that returns to IDLE. busy=0 whenever din_ready=1.
- Back-to-back frames: if din_valid is held high, the next word is accepted on the first IDLE cycle. The line shows the full stop bit plus exactly one idle-high clock before the next start bit.
  - Total frame period with continuous valid = (2+WIDTH+P)*CLK_DIV + 1 cycles.
- CLK_DIV=1: each bit lasts one clock. The divider is held at 0 and every cycle ends a bit.
- tx is driven from a register only; it carries no combinational path from din or din_valid.
- Reset released in the middle of a clock period: the first acceptance can occur on the first rising edge with rst_n=1.

Test Plan:
- Reset and idle: rst_n=0 for 3 cycles, then release with din_valid=0 for 20 cycles -> tx=1, din_ready=1, busy=0, done=0 throughout.
- Single frame (WIDTH=8, CLK_DIV=4, PARITY=0): din=8'hA5 with a one-cycle valid.
  - tx sequence, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1.
  - done pulses exactly 40 cycles after acceptance.
  - din_ready=0 for those 40 cycles.
- Parity modes: din=8'h07.
  - PARITY=1 -> parity bit 1.
  - PARITY=2 -> parity bit 0.
  - Frame is 44 cycles long and done arrives at cycle 44.
- Back-to-back: din_valid held high; din=8'h01, then 8'hFF presented after the first done.
  - Second start bit begins exactly 41 cycles after the first.
  - The receiver-side DFF chain, sampling mid-bit, recovers 8'h01 and 8'hFF.
  - din changes during frame 1 do not corrupt it.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 8'h00.
  - tx goes to 1 before the next clock edge; busy=0, din_ready=1.
  - After release, a new frame with 8'h3C transmits correctly.
- CLK_DIV=1, WIDTH=4, PARITY=0: din=4'b1001 -> tx per cycle 0,1,0,0,1,1; done pulses at cycle 6.

Source files
------------

// File: rtl/piso_tx.sv
// Framed parallel-in serial-out transmitter.
// Sends a start bit, LSB-first data, an optional parity bit and a stop bit on an idle-high line.
module piso_tx #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned PARITY  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PAR_MODE = (PARITY == 1 || PARITY == 2) ? PARITY : 0;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t             state_q, state_nxt;
    logic [DIV_W-1:0]   div_q, div_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic [WIDTH-1:0]   shreg_q, shreg_nxt;
    logic               par_q, par_nxt;
    logic               tx_nxt;
    logic               done_nxt;
    logic               bit_end;
    logic               accept;

    // A CLK_DIV of 1 keeps the divider at zero, so every cycle closes a bit.
    assign bit_end = (div_q == DIV_LAST);
    assign accept  = din_valid && din_ready;

    always_comb begin
        state_nxt = state_q;
        div_nxt   = div_q;
        idx_nxt   = idx_q;
        shreg_nxt = shreg_q;
        par_nxt   = par_q;
        tx_nxt    = tx;
        done_nxt  = 1'b0;

        if (state_q != IDLE) begin
            div_nxt = bit_end ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_nxt  = 1'b1;
                div_nxt = '0;
                idx_nxt = '0;
                if (accept) begin
                    state_nxt = START;
                    shreg_nxt = din;
                    par_nxt   = (PAR_MODE == 2) ? ~(^din) : (^din);
                    tx_nxt    = 1'b0;
                end
            end

            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    tx_nxt    = shreg_q[0];
                end
            end

            DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        if (PAR_MODE != 0) begin
                            state_nxt = PAR;
                            tx_nxt    = par_q;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        idx_nxt   = idx_q + IDX_W'(1);
                        shreg_nxt = shreg_q >> 1;
                        tx_nxt    = shreg_nxt[0];
                    end
                end
            end

            PAR: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end

            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                    done_nxt  = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    // Handshake and status flags are registered off the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            tx        <= 1'b1;
            din_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            div_q     <= div_nxt;
            idx_q     <= idx_nxt;
            shreg_q   <= shreg_nxt;
            par_q     <= par_nxt;
            tx        <= tx_nxt;
            din_ready <= (state_nxt == IDLE);
            busy      <= (state_nxt != IDLE);
            done      <= done_nxt;
        end
    end

endmodule
